// File: rtl/rvecc_pkg.sv
// rvecc_pkg: shared constants, FSM state type and data-to-codeword position map
// for the 39/32 SECDED encoder and checker.
package rvecc_pkg;

   localparam int DATA_W = 32;
   localparam int ECC_W  = 7;
   localparam int CW_W   = 39;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WRITE,
      ST_DONE
   } state_e;

   // Data bits fill the non-power-of-two codeword positions in ascending order.
   function automatic logic [5:0] data_pos(input int unsigned i);
      return (i == 0)  ? 6'd3 :
             (i <= 3)  ? 6'(i + 4) :
             (i <= 10) ? 6'(i + 5) :
             (i <= 25) ? 6'(i + 6) : 6'(i + 7);
   endfunction

endpackage

// File: rtl/rvecc_chk.sv
// rvecc_chk: SECDED checker for a stored 39-bit codeword; corrects single-bit
// errors unless sed_ded selects detect-only operation.
module rvecc_chk
   import rvecc_pkg::*;
(
   input  logic [DATA_W-1:0] din,
   input  logic [ECC_W-1:0]  ecc_in,
   input  logic              sed_ded,
   output logic [DATA_W-1:0] dout,
   output logic              sec,
   output logic              ded
);

   logic [ECC_W-1:0] ecc_calc;
   logic [5:0]       syn;
   logic             par;

   rvecc_gen u_gen (
      .din (din),
      .ecc (ecc_calc)
   );

   assign syn = ecc_calc[5:0] ^ ecc_in[5:0];
   // Overall parity of the received word, rebuilt from the generator's parity bit.
   assign par = ecc_calc[6] ^ ecc_in[6] ^ ^syn;
   assign sec = par & (syn <= 6'd38) & ~sed_ded;
   assign ded = (par | (syn != 6'd0)) & ~sec;

   always_comb begin
      dout = din;
      for (int i = 0; i < DATA_W; i++) dout[i] = din[i] ^ (sec && (syn == data_pos(i)));
   end

endmodule

// File: rtl/rvecc_gen.sv
// rvecc_gen: combinational 32->7 SECDED check-bit generator; ecc[6] makes the
// whole 39-bit codeword even parity.
module rvecc_gen
   import rvecc_pkg::*;
(
   input  logic [DATA_W-1:0] din,
   output logic [ECC_W-1:0]  ecc
);

   always_comb begin
      ecc = '0;
      for (int i = 0; i < DATA_W; i++) ecc[5:0] = ecc[5:0] ^ ({6{din[i]}} & data_pos(i));
      ecc[6] = ^din ^ ^ecc[5:0];
   end

endmodule

// File: rtl/rvecc_wr_encode.sv
// rvecc_wr_encode: SECDED write-path encoder; full writes are encoded directly,
// partial writes use read-modify-write when RVECC_RMW_EN is defined.
module rvecc_wr_encode
   import rvecc_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wbe,
   output logic              mem_rd_valid,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_rvalid,
   input  logic [31:0]       mem_rd_data,
   input  logic [6:0]        mem_rd_ecc,
   output logic              mem_wr_valid,
   input  logic              mem_wr_ready,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [31:0]       mem_wr_data,
   output logic [6:0]        mem_wr_ecc,
   output logic              done_valid,
   output logic              done_err,
   output logic [15:0]       sec_cnt
);

   state_e              state_q, state_d;
   logic                req_ready_q, req_ready_d;
   logic                mem_rd_valid_q, mem_rd_valid_d;
   logic                mem_wr_valid_q, mem_wr_valid_d;
   logic                done_valid_q, done_valid_d;
   logic                done_err_q, done_err_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [ECC_W-1:0]    wr_ecc_q, wr_ecc_d;
   logic [DATA_W-1:0]   enc_din;
   logic [ECC_W-1:0]    enc_ecc;

   rvecc_gen u_gen (
      .din (enc_din),
      .ecc (enc_ecc)
   );

`ifdef RVECC_RMW_EN
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          wbe_q, wbe_d;
   logic [15:0]         sec_cnt_q, sec_cnt_d;
   logic [DATA_W-1:0]   rd_cor, merged;
   logic                rd_sec, rd_ded;

   rvecc_chk u_chk (
      .din     (mem_rd_data),
      .ecc_in  (mem_rd_ecc),
      .sed_ded (1'b0),
      .dout    (rd_cor),
      .sec     (rd_sec),
      .ded     (rd_ded)
   );

   for (genvar b = 0; b < 4; b++) begin : g_merge
      assign merged[8*b +: 8] = wbe_q[b] ? wdata_q[8*b +: 8] : rd_cor[8*b +: 8];
   end

   // The single generator serves both the direct full-write and the RMW merge.
   assign enc_din = (state_q == ST_RD_WAIT) ? merged : req_wdata;
   assign sec_cnt = sec_cnt_q;
`else
   logic unused_rd;

   assign unused_rd = ^{mem_rd_rvalid, mem_rd_data, mem_rd_ecc};
   assign enc_din   = req_wdata;
   assign sec_cnt   = '0;
`endif

   always_comb begin
      state_d        = state_q;
      mem_rd_valid_d = 1'b0;
      mem_wr_valid_d = mem_wr_valid_q;
      done_valid_d   = 1'b0;
      done_err_d     = done_err_q;
      addr_d         = addr_q;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      wr_ecc_d       = wr_ecc_q;
`ifdef RVECC_RMW_EN
      wdata_d        = wdata_q;
      wbe_d          = wbe_q;
      sec_cnt_d      = sec_cnt_q;
`endif
      case (state_q)
         ST_IDLE: if (req_valid) begin
            addr_d = req_addr;
`ifdef RVECC_RMW_EN
            wdata_d = req_wdata;
            wbe_d   = req_wbe;
`endif
            if (&req_wbe) begin
               state_d        = ST_WRITE;
               mem_wr_valid_d = 1'b1;
               wr_addr_d      = req_addr;
               wr_data_d      = req_wdata;
               wr_ecc_d       = enc_ecc;
            end else if (req_wbe == 4'h0) begin
               state_d      = ST_DONE;
               done_valid_d = 1'b1;
            end else begin
`ifdef RVECC_RMW_EN
               state_d        = ST_RD_REQ;
               mem_rd_valid_d = 1'b1;
`else
               state_d      = ST_DONE;
               done_valid_d = 1'b1;
               done_err_d   = 1'b1;
`endif
            end
         end
`ifdef RVECC_RMW_EN
         ST_RD_REQ: state_d = ST_RD_WAIT;
         ST_RD_WAIT: if (mem_rd_rvalid) begin
            if (rd_ded) begin
               state_d      = ST_DONE;
               done_valid_d = 1'b1;
               done_err_d   = 1'b1;
            end else begin
               state_d        = ST_WRITE;
               mem_wr_valid_d = 1'b1;
               wr_addr_d      = addr_q;
               wr_data_d      = merged;
               wr_ecc_d       = enc_ecc;
               sec_cnt_d      = sec_cnt_q + 16'(rd_sec & ~&sec_cnt_q);
            end
         end
`endif
         ST_WRITE: if (mem_wr_ready) begin
            state_d        = ST_DONE;
            mem_wr_valid_d = 1'b0;
            done_valid_d   = 1'b1;
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            done_err_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q        <= ST_IDLE;
         req_ready_q    <= 1'b1;
         mem_rd_valid_q <= 1'b0;
         mem_wr_valid_q <= 1'b0;
         done_valid_q   <= 1'b0;
         done_err_q     <= 1'b0;
         addr_q         <= '0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         wr_ecc_q       <= '0;
`ifdef RVECC_RMW_EN
         wdata_q        <= '0;
         wbe_q          <= '0;
         sec_cnt_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         req_ready_q    <= req_ready_d;
         mem_rd_valid_q <= mem_rd_valid_d;
         mem_wr_valid_q <= mem_wr_valid_d;
         done_valid_q   <= done_valid_d;
         done_err_q     <= done_err_d;
         addr_q         <= addr_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         wr_ecc_q       <= wr_ecc_d;
`ifdef RVECC_RMW_EN
         wdata_q        <= wdata_d;
         wbe_q          <= wbe_d;
         sec_cnt_q      <= sec_cnt_d;
`endif
      end
   end

   assign req_ready    = req_ready_q;
   assign mem_rd_valid = mem_rd_valid_q;
   assign mem_rd_addr  = addr_q;
   assign mem_wr_valid = mem_wr_valid_q;
   assign mem_wr_addr  = wr_addr_q;
   assign mem_wr_data  = wr_data_q;
   assign mem_wr_ecc   = wr_ecc_q;
   assign done_valid   = done_valid_q;
   assign done_err     = done_err_q;

endmodule

// File: tb/tb_rvecc_wr_encode.sv
// tb_rvecc_wr_encode: directed and randomized checks of the SECDED write encoder
module tb_rvecc_wr_encode;
  localparam int ADDR_W = 16;
  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_wbe = '0;
  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_rvalid = 1'b0;
  logic [31:0]       mem_rd_data = '0;
  logic [6:0]        mem_rd_ecc = '0;
  logic              mem_wr_valid;
  logic              mem_wr_ready = 1'b1;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic [6:0]        mem_wr_ecc;
  logic              done_valid;
  logic              done_err;
  logic [15:0]       sec_cnt;
  int          checks = 0;
  int          passes = 0;
  logic [15:0] sec_exp = '0;

  rvecc_wr_encode #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wbe       (req_wbe),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_rvalid (mem_rd_rvalid),
    .mem_rd_data   (mem_rd_data),
    .mem_rd_ecc    (mem_rd_ecc),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_ready  (mem_wr_ready),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ecc    (mem_wr_ecc),
    .done_valid    (done_valid),
    .done_err      (done_err),
    .sec_cnt       (sec_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  e;
    int          n;
    cw = '0;
    e  = '0;
    n  = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[n];
        n++;
      end
    for (int k = 0; k < 6; k++)
      for (int p = 1; p <= 38; p++)
        if (p[k]) e[k] = e[k] ^ cw[p];
    e[6] = ^cw ^ ^e[5:0];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    checks++; if (req_ready === 1'b1) passes++; else $error("FAIL req_ready_before_accept: %0h", req_ready);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_wbe   = be;
    step();
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    req_wbe   = 4'($urandom);
  endtask

  task automatic full_write(input logic [15:0] a, input logic [31:0] d, input logic [6:0] e, input int stall);
    mem_wr_ready = (stall == 0);
    issue(a, d, 4'hF);
    checks++; if (mem_wr_valid === 1'b1) passes++; else $error("FAIL wr_valid_n1");
    checks++; if (mem_wr_addr === a) passes++; else $error("FAIL wr_addr: %0h vs %0h", mem_wr_addr, a);
    checks++; if (mem_wr_data === d) passes++; else $error("FAIL wr_data: %0h vs %0h", mem_wr_data, d);
    checks++; if (mem_wr_ecc === e) passes++; else $error("FAIL wr_ecc: %0h vs %0h", mem_wr_ecc, e);
    checks++; if (req_ready === 1'b0) passes++; else $error("FAIL req_ready_busy");
    for (int i = 0; i < stall; i++) begin
      step();
      checks++; if (mem_wr_valid === 1'b1) passes++; else $error("FAIL stall_valid");
      checks++; if ({mem_wr_addr, mem_wr_data, mem_wr_ecc} === {a, d, e}) passes++; else $error("FAIL stall_data");
      checks++; if (req_ready === 1'b0) passes++; else $error("FAIL stall_ready");
      checks++; if (done_valid === 1'b0) passes++; else $error("FAIL stall_done");
    end
    mem_wr_ready = 1'b1;
    step();
    checks++; if (done_valid === 1'b1) passes++; else $error("FAIL done_valid");
    checks++; if (done_err === 1'b0) passes++; else $error("FAIL done_err");
    checks++; if (mem_wr_valid === 1'b0) passes++; else $error("FAIL wr_valid_drop");
    step();
    checks++; if (done_valid === 1'b0) passes++; else $error("FAIL done_one_cycle");
    checks++; if (req_ready === 1'b1) passes++; else $error("FAIL req_ready_back");
  endtask

  task automatic no_write(input logic [15:0] a);
    issue(a, $urandom, 4'h0);
    checks++; if (mem_wr_valid === 1'b0) passes++; else $error("FAIL wbe0_no_wr");
    checks++; if (mem_rd_valid === 1'b0) passes++; else $error("FAIL wbe0_no_rd");
    checks++; if ({done_valid, done_err} === 2'b10) passes++; else $error("FAIL wbe0_done");
    step();
    checks++; if (req_ready === 1'b1) passes++; else $error("FAIL wbe0_ready");
  endtask

  task automatic partial(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] s, input logic [38:0] flip, input int dly);
`ifdef RVECC_RMW_EN
    logic [38:0] cw;
    logic [31:0] m;
    int          nf;
    cw = {ref_ecc(s), s} ^ flip;
    nf = $countones(flip);
    for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? d[8*b +: 8] : s[8*b +: 8];
    mem_wr_ready = 1'b1;
    issue(a, d, be);
    checks++; if (mem_rd_valid === 1'b1) passes++; else $error("FAIL rd_valid");
    checks++; if (mem_rd_addr === a) passes++; else $error("FAIL rd_addr");
    checks++; if (mem_wr_valid === 1'b0) passes++; else $error("FAIL rd_no_wr");
    step();
    checks++; if (mem_rd_valid === 1'b0) passes++; else $error("FAIL rd_valid_pulse");
    for (int i = 0; i < dly; i++) begin
      step();
      checks++; if (mem_wr_valid === 1'b0) passes++; else $error("FAIL rd_wait_no_wr");
    end
    mem_rd_rvalid = 1'b1;
    mem_rd_data   = cw[31:0];
    mem_rd_ecc    = cw[38:32];
    step();
    mem_rd_rvalid = 1'b0;
    mem_rd_data   = $urandom;
    if (nf >= 2) begin
      checks++; if (mem_wr_valid === 1'b0) passes++; else $error("FAIL ded_no_wr");
      checks++; if ({done_valid, done_err} === 2'b11) passes++; else $error("FAIL ded_done");
      checks++; if (sec_cnt === sec_exp) passes++; else $error("FAIL ded_sec_cnt");
      step();
      checks++; if ({req_ready, done_valid, done_err, mem_wr_valid} === 4'b1000) passes++; else $error("FAIL ded_ready");
    end else begin
      if (nf == 1 && sec_exp != 16'hFFFF) sec_exp++;
      checks++; if (mem_wr_valid === 1'b1) passes++; else $error("FAIL rmw_wr_valid");
      checks++; if (mem_wr_addr === a) passes++; else $error("FAIL rmw_wr_addr");
      checks++; if (mem_wr_data === m) passes++; else $error("FAIL rmw_wr_data: %0h vs %0h", mem_wr_data, m);
      checks++; if (mem_wr_ecc === ref_ecc(m)) passes++; else $error("FAIL rmw_wr_ecc");
      checks++; if (sec_cnt === sec_exp) passes++; else $error("FAIL rmw_sec_cnt: %0h vs %0h", sec_cnt, sec_exp);
      step();
      checks++; if ({done_valid, done_err, mem_wr_valid} === 3'b100) passes++; else $error("FAIL rmw_done");
      step();
      checks++; if ({req_ready, done_valid} === 2'b10) passes++; else $error("FAIL rmw_ready");
    end
`else
    issue(a, d ^ s ^ flip[31:0], be);
    checks++; if (mem_rd_valid === 1'b0) passes++; else $error("FAIL part_no_rd");
    checks++; if (mem_wr_valid === 1'b0) passes++; else $error("FAIL part_no_wr");
    checks++; if ({done_valid, done_err} === 2'b11) passes++; else $error("FAIL part_done_err");
    for (int i = 0; i < dly; i++) step();
    if (dly == 0) step();
    checks++; if ({req_ready, done_valid, mem_wr_valid, mem_rd_valid} === 4'b1000) passes++; else $error("FAIL part_ready");
    checks++; if (sec_cnt === 16'h0000) passes++; else $error("FAIL part_sec_cnt");
`endif
  endtask

  task automatic check_reset_state(input string tag);
    checks++; if ({req_ready, mem_rd_valid, mem_wr_valid, done_valid, done_err} === 5'b10000) passes++; else $error("FAIL %s", tag);
    checks++; if ({mem_wr_addr, mem_wr_data, mem_wr_ecc} === 55'h0) passes++; else $error("FAIL reset_wr_regs");
    checks++; if (sec_cnt === 16'h0000) passes++; else $error("FAIL reset_sec_cnt");
  endtask

  initial begin
    step();
    step();
    check_reset_state("reset_outputs");
    rst_l = 1'b1;
    step();
    full_write(16'h0001, 32'h00000000, 7'h00, 0);
    full_write(16'h0002, 32'h00000001, 7'h43, 0);
    full_write(16'hFFFF, 32'hFFFFFFFF, 7'h18, 0);
    no_write(16'h0004);
    partial(16'h0010, 32'hAABBCCDD, 4'b0010, 32'h11223344, 39'h0, 2);
    partial(16'h0011, 32'hAABBCCDD, 4'b0010, 32'h11223344, 39'h1 << 5, 0);
    partial(16'h0012, 32'h5A5AA5A5, 4'b1001, 32'h0F0F0F0F, (39'h1 << 3) | (39'h1 << 17), 1);
    full_write(16'h1234, 32'hDEADBEEF, ref_ecc(32'hDEADBEEF), 10);
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  be;
      logic [31:0] d, s;
      logic [38:0] fl;
      int          j1, j2;
      be = 4'($urandom_range(0, 15));
      d  = $urandom;
      s  = $urandom;
      j1 = int'($urandom_range(0, 38));
      j2 = (j1 + int'($urandom_range(1, 38))) % 39;
      fl = '0;
      case ($urandom_range(0, 2))
        1: fl[j1] = 1'b1;
        2: begin
          fl[j1] = 1'b1;
          fl[j2] = 1'b1;
        end
        default: ;
      endcase
      if (be == 4'hF) full_write(16'(i * 7), d, ref_ecc(d), int'($urandom_range(0, 3)));
      else if (be == 4'h0) no_write(16'(i * 7));
      else partial(16'(i * 7), d, be, s, fl, int'($urandom_range(0, 3)));
    end
`ifdef RVECC_RMW_EN
    issue(16'h0BAD, 32'h01234567, 4'b0110);
    step();
`else
    mem_wr_ready = 1'b0;
    issue(16'h0BAD, 32'h01234567, 4'hF);
    step();
`endif
    rst_l = 1'b0;
    step();
    sec_exp = '0;
    check_reset_state("midop_reset");
    rst_l         = 1'b1;
    mem_wr_ready  = 1'b1;
    mem_rd_rvalid = 1'b1;
    mem_rd_data   = 32'h01234567;
    mem_rd_ecc    = ref_ecc(32'h01234567);
    step();
    mem_rd_rvalid = 1'b0;
    checks++; if ({req_ready, mem_wr_valid, done_valid, mem_rd_valid} === 4'b1000) passes++; else $error("FAIL stale_rvalid_ignored");
    step();
    checks++; if ({done_valid, mem_wr_valid} === 2'b00) passes++; else $error("FAIL stale_no_done");
    full_write(16'h0C0C, 32'hCAFEF00D, ref_ecc(32'hCAFEF00D), 1);
    partial(16'h0C0D, 32'h89ABCDEF, 4'b0100, 32'h13579BDF, 39'h1 << 36, 1);
`ifdef RVECC_RMW_EN
    force dut.sec_cnt_q = 16'hFFFE;
    step();
    release dut.sec_cnt_q;
    step();
    sec_exp = 16'hFFFE;
    checks++; if (sec_cnt === 16'hFFFE) passes++; else $error("FAIL sec_preload");
    partial(16'h0E00, 32'h0, 4'b0001, 32'hFEDCBA98, 39'h1 << 9, 0);
    checks++; if (sec_cnt === 16'hFFFF) passes++; else $error("FAIL sec_reach_max");
    partial(16'h0E01, 32'h0, 4'b1000, 32'h76543210, 39'h1 << 30, 0);
    checks++; if (sec_cnt === 16'hFFFF) passes++; else $error("FAIL sec_saturated");
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
